regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile.sv | 33 +++
 tb/tb_regfile.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, constants and read-port priority function
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'h0;
  function automatic logic [DATA_W-1:0] read_port(
    input logic rst,
    input logic en,
    input logic [REG_ADDR_W-1:0] addr,
    input logic wb_reg,
    input logic [REG_ADDR_W-1:0] wb_wd,
    input logic [DATA_W-1:0] wb_wdata,
    input logic [DATA_W-1:0] stored
  );
    return (!rst || !en || addr == NOP_REG_ADDR) ? ZERO_WORD :
           (wb_reg && wb_wd == addr) ? wb_wdata : stored;
  endfunction
endpackage

// File: rtl/regfile.sv
// regfile: 31x32 register file, x0 hardwired to zero, two combinational read ports with write-through bypass
module regfile
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wb_wd,
  input  logic                  wb_reg,
  input  logic [DATA_W-1:0]     wb_wdata,
  input  logic                  reg1_read,
  input  logic [REG_ADDR_W-1:0] reg1_addr,
  output logic [DATA_W-1:0]     reg1_data,
  input  logic                  reg2_read,
  input  logic [REG_ADDR_W-1:0] reg2_addr,
  output logic [DATA_W-1:0]     reg2_data
);
  logic [DATA_W-1:0] regs [1:REG_NUM-1];
  logic [DATA_W-1:0] stored1, stored2;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < REG_NUM; i++) regs[i] <= ZERO_WORD;
    end else if (wb_reg && wb_wd != NOP_REG_ADDR) begin
      regs[wb_wd] <= wb_wdata;
    end
  end
  // index 0 has no storage; guard the array lookup so it stays in range
  always_comb begin
    stored1 = (reg1_addr == NOP_REG_ADDR) ? ZERO_WORD : regs[reg1_addr];
    stored2 = (reg2_addr == NOP_REG_ADDR) ? ZERO_WORD : regs[reg2_addr];
    reg1_data = read_port(rst, reg1_read, reg1_addr, wb_reg, wb_wd, wb_wdata, stored1);
    reg2_data = read_port(rst, reg2_read, reg2_addr, wb_reg, wb_wd, wb_wdata, stored2);
  end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile
module tb_regfile;
  logic        clk = 0;
  logic        rst = 0;
  logic [4:0]  wb_wd = 0;
  logic        wb_reg = 0;
  logic [31:0] wb_wdata = 0;
  logic        reg1_read = 0;
  logic [4:0]  reg1_addr = 0;
  logic [31:0] reg1_data;
  logic        reg2_read = 0;
  logic [4:0]  reg2_addr = 0;
  logic [31:0] reg2_data;
  int errors = 0;
  int checks = 0;

  regfile dut (
    .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_reg(wb_reg), .wb_wdata(wb_wdata),
    .reg1_read(reg1_read), .reg1_addr(reg1_addr), .reg1_data(reg1_data),
    .reg2_read(reg2_read), .reg2_addr(reg2_addr), .reg2_data(reg2_data)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_reg = 1; wb_wd = a; wb_wdata = d;
    @(posedge clk);
    #1 wb_reg = 0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    reg1_read = 1; reg2_read = 1; reg1_addr = a1; reg2_addr = a2;
    #1;
  endtask

  task automatic test_reset;
    set_reads(5'd3, 5'd4);
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      errors++; $display("FAIL reset_out r1=%h r2=%h want 0", reg1_data, reg2_data);
    end
    @(negedge clk) rst = 1;
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(31 - i));
      checks++;
      if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
        errors++; $display("FAIL reset_sweep idx=%0d r1=%h r2=%h want 0", i, reg1_data, reg2_data);
      end
    end
  endtask

  task automatic test_write_read;
    do_write(5'd5, 32'hDEADBEEF);
    set_reads(5'd5, 5'd5);
    checks++;
    if (reg1_data !== 32'hDEADBEEF || reg2_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read r1=%h r2=%h want deadbeef", reg1_data, reg2_data);
    end
    @(posedge clk); #1;
    checks++;
    if (reg1_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_read_hold r1=%h want deadbeef", reg1_data);
    end
    set_reads(5'd6, 5'd4);
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      errors++; $display("FAIL write_neighbours r1=%h r2=%h want 0", reg1_data, reg2_data);
    end
  endtask

  task automatic test_bypass;
    do_write(5'd7, 32'h1);
    @(negedge clk);
    wb_reg = 1; wb_wd = 5'd7; wb_wdata = 32'h2;
    set_reads(5'd7, 5'd7);
    checks++;
    if (reg1_data !== 32'h2 || reg2_data !== 32'h2) begin
      errors++; $display("FAIL bypass r1=%h r2=%h want 2", reg1_data, reg2_data);
    end
    @(posedge clk); #1 wb_reg = 0; #1;
    checks++;
    if (reg1_data !== 32'h2 || reg2_data !== 32'h2) begin
      errors++; $display("FAIL bypass_stored r1=%h r2=%h want 2", reg1_data, reg2_data);
    end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    wb_reg = 1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
    set_reads(5'd0, 5'd0);
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      errors++; $display("FAIL zero_same_cycle r1=%h r2=%h want 0", reg1_data, reg2_data);
    end
    @(posedge clk); #1 wb_reg = 0; #1;
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      errors++; $display("FAIL zero_after r1=%h r2=%h want 0", reg1_data, reg2_data);
    end
    set_reads(5'd5, 5'd7);
    checks++;
    if (reg1_data !== 32'hDEADBEEF || reg2_data !== 32'h2) begin
      errors++; $display("FAIL zero_no_side r1=%h r2=%h want deadbeef/2", reg1_data, reg2_data);
    end
  endtask

  task automatic test_wb_disable;
    @(negedge clk);
    wb_reg = 0; wb_wd = 5'd5; wb_wdata = 32'h0BADF00D;
    set_reads(5'd5, 5'd5);
    checks++;
    if (reg1_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wb_off_nobypass r1=%h want deadbeef", reg1_data);
    end
    @(posedge clk); #1;
    checks++;
    if (reg2_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wb_off_nowrite r2=%h want deadbeef", reg2_data);
    end
  endtask

  task automatic test_read_disable;
    do_write(5'd3, 32'hA5A5A5A5);
    set_reads(5'd3, 5'd3);
    reg1_read = 0; #1;
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL read_disable r1=%h r2=%h want 0/a5a5a5a5", reg1_data, reg2_data);
    end
    @(negedge clk);
    wb_reg = 1; wb_wd = 5'd3; wb_wdata = 32'h3C3C3C3C; #1;
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h3C3C3C3C) begin
      errors++; $display("FAIL read_disable_bypass r1=%h r2=%h want 0/3c3c3c3c", reg1_data, reg2_data);
    end
    @(posedge clk); #1 wb_reg = 0;
    reg1_read = 1;
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 4; i++) do_write(5'(16 + i), 32'h100 * i + 32'h11);
    for (int i = 1; i <= 4; i += 2) begin
      set_reads(5'(16 + i), 5'(17 + i));
      checks++;
      if (reg1_data !== 32'h100 * i + 32'h11 || reg2_data !== 32'h100 * (i + 1) + 32'h11) begin
        errors++; $display("FAIL back_to_back i=%0d r1=%h r2=%h", i, reg1_data, reg2_data);
      end
    end
    do_write(5'd31, 32'hCAFEF00D);
    set_reads(5'd31, 5'd31);
    checks++;
    if (reg1_data !== 32'hCAFEF00D || reg2_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL top_index r1=%h r2=%h want cafef00d", reg1_data, reg2_data);
    end
  endtask

  task automatic test_async_reset;
    do_write(5'd9, 32'h12345678);
    set_reads(5'd9, 5'd9);
    @(negedge clk); #2 rst = 0; #1;
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      errors++; $display("FAIL async_reset_out r1=%h r2=%h want 0", reg1_data, reg2_data);
    end
    rst = 1; #1;
    checks++;
    if (reg1_data !== 32'h0 || reg2_data !== 32'h0) begin
      errors++; $display("FAIL async_reset_clear r1=%h r2=%h want 0", reg1_data, reg2_data);
    end
    @(negedge clk);
    rst = 0; wb_reg = 1; wb_wd = 5'd9; wb_wdata = 32'h87654321;
    @(posedge clk); #1 wb_reg = 0; rst = 1; #1;
    checks++;
    if (reg1_data !== 32'h0) begin
      errors++; $display("FAIL reset_blocks_write r1=%h want 0", reg1_data);
    end
    do_write(5'd10, 32'h55AA55AA);
    set_reads(5'd10, 5'd5);
    checks++;
    if (reg1_data !== 32'h55AA55AA || reg2_data !== 32'h0) begin
      errors++; $display("FAIL post_reset_write r1=%h r2=%h want 55aa55aa/0", reg1_data, reg2_data);
    end
  endtask

  initial begin
    #12;
    test_reset;
    test_write_read;
    test_bypass;
    test_zero_reg;
    test_wb_disable;
    test_read_disable;
    test_back_to_back;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
